// File: rtl/hazard_ctl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM encoding, widths
// and the load-use decode rule.
package hazard_ctl_pkg;

    localparam int CNT_W  = 16;
    localparam int CTRL_W = 10;
    localparam int REG_W  = 5;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Register 0 is hard-wired to zero, so a load targeting it never creates a hazard.
    function automatic logic is_load_use(
        input logic             ex_memread,
        input logic [REG_W-1:0] ex_rt,
        input logic [REG_W-1:0] id_rs,
        input logic [REG_W-1:0] id_rt,
        input logic             id_uses_rt
    );
        return ex_memread && (ex_rt != '0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/hazard_ctl_if.sv
// Pipeline-side signal bundle of the hazard controller; the slave modport is
// the controller's view, the master modport the pipeline's view.
interface hazard_ctl_if;
    import hazard_ctl_pkg::*;

    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic             ex_memread;
    logic [REG_W-1:0] ex_rt;
    logic             mem_branch_taken;
    logic             ext_stall;

    logic             pc_write;
    logic             ifid_write;
    logic             idex_bubble;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             busy;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, mem_branch_taken, ext_stall,
        input  pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush,
               stall_cnt, flush_cnt, busy
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, mem_branch_taken, ext_stall,
        output pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush,
               stall_cnt, flush_cnt, busy
    );

endinterface

// File: rtl/hazard_ctl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    // NOTE: sequential state is always updated with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and
// external multi-cycle hold (RUN -> HOLD -> DRAIN -> RUN), plus event counters.
module hazard_ctl
    import hazard_ctl_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    hazard_ctl_if.slave  bus
);

    state_t r_state;
    state_t w_next;
    logic   w_load_use;
    logic   w_pc_write;
    logic   w_ifid_write;
    logic   w_idex_bubble;
    logic   w_flush;

    assign w_load_use = is_load_use(bus.ex_memread, bus.ex_rt, bus.id_rs,
                                    bus.id_rt, bus.id_uses_rt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next        = r_state;
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_idex_bubble = 1'b0;
        w_flush       = 1'b0;

        if (rst) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
            w_flush       = 1'b1;
            w_next        = ST_RUN;
        end else if (bus.mem_branch_taken) begin
            // The redirect wins; a bubble would be wiped by the flush anyway.
            w_flush = 1'b1;
            w_next  = bus.ext_stall ? ST_HOLD : ST_RUN;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    if (bus.ext_stall || w_load_use) begin
                        w_pc_write    = 1'b0;
                        w_ifid_write  = 1'b0;
                        w_idex_bubble = 1'b1;
                    end
                    if (bus.ext_stall) begin
                        w_next = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    w_pc_write    = 1'b0;
                    w_ifid_write  = 1'b0;
                    w_idex_bubble = 1'b1;
                    w_next        = bus.ext_stall ? ST_HOLD : ST_DRAIN;
                end
                ST_DRAIN: begin
                    w_pc_write    = 1'b0;
                    w_idex_bubble = 1'b1;
                    w_next        = bus.ext_stall ? ST_HOLD : ST_RUN;
                end
                default: begin
                    w_next = ST_RUN;
                end
            endcase
        end
    end

    assign bus.pc_write    = w_pc_write;
    assign bus.ifid_write  = w_ifid_write;
    assign bus.idex_bubble = w_idex_bubble;
    assign bus.ifid_flush  = w_flush;
    assign bus.idex_flush  = w_flush;
    assign bus.exmem_flush = w_flush;
    assign bus.busy        = (r_state == ST_HOLD) || (r_state == ST_DRAIN);

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (!w_pc_write),
        .o_cnt (bus.stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_flush),
        .o_cnt (bus.flush_cnt)
    );

endmodule
